tc_multi: RTL and testbench
===========================

// Module: tc_multi
// PURPOSE
//   Parametrised multi-channel down-counting timer; successor to the single 32-bit timer.
//   NCH independent channels, each CNT_W wide, with one-shot, periodic, and pulse modes.
//   Per-channel sticky interrupt status (write-1-to-clear); single OR-reduced IRQ.
//   Sits on the bridge as a memory-mapped device at BASE; IRQ feeds the CP0 HWInt input.
// PARAMETERS
//   BASE   `DEV0ADDR_BEGIN  byte base address of the register window
//   NCH    2                channel count, 1..8
//   CNT_W  32               counter/preset width, 8..32; reads zero-extended to 32
// PORTS
//   clk    in   1   system clock, rising edge
//   reset  in   1   asynchronous, active-high; clears all state
//   addr   in   16  byte address from the bridge
//   we     in   1   write strobe, qualified by addr in window
//   wd     in   32  write data
//   RD     out  32  combinational read data; 0 for unmapped offsets
//   IRQ    out  1   |(STATUS & per-channel IM)
// BEHAVIOUR
//   Map: off = addr-BASE; ch = off[6:4] (ch<NCH); reg = off[3:0].
//     0x0 CTRL  [3]IM [2:1]MODE [0]EN, rest read 0   0x4 PRESET  0x8 COUNT (read-only)
//     0x80 STATUS [NCH-1:0]: read sticky flags; write 1 clears bit; other offsets RD=0
//   MODE: 00 one-shot (HW clears EN at terminal); 01 periodic (auto-reload, keep running);
//     10 pulse (periodic, flag self-clears next cycle); 11 treated as 01
//   Per-channel FSM: IDLE -EN=1-> LOAD (count<=preset) -> CNT.
//     CNT: EN=0 -> IDLE, count holds. count<=1 -> terminal: set flag;
//     mode 00 -> EN<=0, IDLE; mode 01/10/11 -> count<=preset, stay CNT. Else count<=count-1.
//   Terminal latency: preset=P>=1 -> flag set P+1 cycles after the EN write edge
//     (1 LOAD + P CNT). P=0 behaves as P=1.
//   Writes: CTRL/PRESET write to channel c stalls channel c that cycle (no FSM step);
//     other channels unaffected. PRESET change takes effect at next LOAD/reload only.
//   STATUS: set has priority over W1C clear in same cycle. Pulse-mode flag clears after 1 cycle
//     unless re-set. Flags are set regardless of IM; IM masks only IRQ.
//   Re-enable from IDLE always passes through LOAD (count reloaded from PRESET).
//   Reset (any time, incl. mid-count): CTRL/PRESET/COUNT/STATUS=0, all FSMs IDLE,
//     IRQ=0 immediately (async); RD reflects zeroed regs.
//   Arithmetic: unsigned CNT_W; no underflow wrap (terminal caught at <=1).
//   Out-of-window or ch>=NCH writes ignored.
// STRUCTURE
//   Shared header tc_defs.vh: register offsets (CTRL/PRESET/COUNT/STATUS), channel stride 0x10,
//     MODE encodings, FSM state encodings.
//   Sub-module tc_channel (CNT_W): one channel's regs + FSM, outputs ctrl/preset/count,
//     term pulse; top generates NCH instances, decodes addr, owns STATUS and IRQ.
// TESTING
//   1 ch0 PRESET=3, CTRL=0b1001 (IM, one-shot, EN) -> STATUS[0]=1 at 4th edge after write,
//     CTRL[0] reads 0, IRQ=1; write STATUS=1 -> IRQ=0 next cycle.
//   2 ch1 PRESET=2, mode 01, IM=1 -> STATUS[1] set every 2 cycles after first terminal,
//     COUNT sequence 2,1,2,1; clear then re-set observed without gaps.
//   3 ch0 mode 10, PRESET=4, IM=1 -> IRQ high exactly 1 cycle every 4 cycles.
//   4 W1C on STATUS[0] same cycle as ch0 terminal -> bit remains 1; ch0 IM=0 -> IRQ=0, STATUS=1.
//   5 CNT_W=8, PRESET=0xFF, mid-count (COUNT=0x80) assert reset -> all regs 0, IRQ=0
//     asynchronously; COUNT reads 32'h0; writing addr BASE+0x20 with NCH=2 has no effect.

Source files
------------

// File: rtl/tc_multi_pkg.sv
// Shared definitions for the multi-channel timer: register offsets,
// control-field layout, mode and channel-FSM encodings.
package tc_multi_pkg;

    // Register offsets inside one channel's 16-byte slot
    localparam logic [3:0]  REG_CTRL   = 4'h0;
    localparam logic [3:0]  REG_PRESET = 4'h4;
    localparam logic [3:0]  REG_COUNT  = 4'h8;

    // Shared status register and window geometry
    localparam logic [7:0]  OFF_STATUS = 8'h80;
    localparam int          CH_STRIDE  = 16;
    localparam logic [15:0] WIN_BYTES  = 16'h0100;

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'b00,
        MODE_PERIODIC = 2'b01,
        MODE_PULSE    = 2'b10,
        MODE_PER_ALT  = 2'b11
    } tc_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_CNT  = 2'b10
    } tc_state_e;

    // CTRL register layout: [3] IM, [2:1] MODE, [0] EN
    typedef struct packed {
        logic     im;
        tc_mode_e mode;
        logic     en;
    } tc_ctrl_t;

    // Pulse-mode flags only live for one cycle unless set again
    function automatic logic self_clearing(input tc_mode_e m);
        return m == MODE_PULSE;
    endfunction

endpackage

// File: rtl/tc_multi_channel.sv
// One timer channel: CTRL/PRESET/COUNT registers and the IDLE/LOAD/CNT FSM.
// A CTRL or PRESET write to this channel freezes the FSM for that cycle,
// except that enabling an idle channel moves it straight into LOAD.
module tc_channel
    import tc_multi_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_ctrl,
    input  logic             wr_preset,
    input  logic [CNT_W-1:0] wd,
    output tc_ctrl_t         ctrl,
    output logic [CNT_W-1:0] preset,
    output logic [CNT_W-1:0] count,
    output logic             term
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    tc_state_e state, state_nxt;
    logic      stall, kick, at_term;
    logic      load_cnt, dec_cnt, clr_en;

    assign stall   = wr_ctrl | wr_preset;
    assign kick    = wr_ctrl & wd[0] & (state == ST_IDLE);
    // Terminal is caught at 1 (or 0) so the counter never wraps
    assign at_term = count <= ONE;

    // State register: kick on enabling write, otherwise advance unless stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       state <= ST_IDLE;
        else if (kick)   state <= ST_LOAD;
        else if (!stall) state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (ctrl.en) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ctrl.en ? ST_CNT : ST_IDLE;
            ST_CNT: begin
                if (!ctrl.en)                                  state_nxt = ST_IDLE;
                else if (at_term && ctrl.mode == MODE_ONESHOT) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: terminal pulse and counter/enable commands
    always_comb begin
        term     = 1'b0;
        load_cnt = 1'b0;
        dec_cnt  = 1'b0;
        clr_en   = 1'b0;
        if (!stall) begin
            case (state)
                ST_LOAD: load_cnt = ctrl.en;
                ST_CNT: begin
                    if (ctrl.en) begin
                        if (at_term) begin
                            term = 1'b1;
                            if (ctrl.mode == MODE_ONESHOT) clr_en   = 1'b1;
                            else                           load_cnt = 1'b1;
                        end else begin
                            dec_cnt = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // CTRL register; hardware drops EN when a one-shot expires
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        ctrl    <= '0;
        else if (wr_ctrl) ctrl    <= tc_ctrl_t'(wd[3:0]);
        else if (clr_en)  ctrl.en <= 1'b0;
    end

    // PRESET register; only sampled at LOAD or reload
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          preset <= '0;
        else if (wr_preset) preset <= wd;
    end

    // Down counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         count <= '0;
        else if (load_cnt) count <= preset;
        else if (dec_cnt)  count <= count - ONE;
    end

endmodule

// File: rtl/tc_multi.sv
// Multi-channel down-counting timer on the bridge. Decodes the register
// window at BASE, instantiates NCH channels, owns sticky STATUS and IRQ.
module tc_multi
    import tc_multi_pkg::*;
#(
    parameter logic [15:0] BASE  = 16'h7F00,
    parameter int          NCH   = 2,
    parameter int          CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] RD,
    output logic        IRQ
);

    logic [15:0]    off;
    logic           in_win, is_ch, is_status;
    logic [2:0]     ch_sel;
    logic [3:0]     reg_sel;

    tc_ctrl_t       ctrl_arr   [NCH];
    logic [CNT_W-1:0] preset_arr [NCH];
    logic [CNT_W-1:0] count_arr  [NCH];
    logic [NCH-1:0] term_vec, im_vec, self_clr, w1c, status, status_nxt;

    // Upper write-data bits beyond CNT_W/NCH carry no state
    logic unused_wd;
    assign unused_wd = ^wd;

    assign off       = addr - BASE;
    assign in_win    = off < WIN_BYTES;
    assign ch_sel    = off[6:4];
    assign reg_sel   = off[3:0];
    assign is_ch     = in_win & ~off[7] & (int'(ch_sel) < NCH);
    assign is_status = in_win & (off[7:0] == OFF_STATUS);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic sel;
        assign sel = we & is_ch & (ch_sel == 3'(g));

        tc_channel #(.CNT_W(CNT_W)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .wr_ctrl   (sel & (reg_sel == REG_CTRL)),
            .wr_preset (sel & (reg_sel == REG_PRESET)),
            .wd        (wd[CNT_W-1:0]),
            .ctrl      (ctrl_arr[g]),
            .preset    (preset_arr[g]),
            .count     (count_arr[g]),
            .term      (term_vec[g])
        );

        assign im_vec[g]   = ctrl_arr[g].im;
        assign self_clr[g] = self_clearing(ctrl_arr[g].mode);
    end

    // Set beats write-1-to-clear; pulse-mode flags drop after one cycle
    assign w1c        = (we & is_status) ? wd[NCH-1:0] : '0;
    assign status_nxt = term_vec | (status & ~w1c & ~self_clr);

    // Sticky interrupt status
    always_ff @(posedge clk or posedge reset) begin
        if (reset) status <= '0;
        else       status <= status_nxt;
    end

    assign IRQ = |(status & im_vec);

    // Combinational read mux, zero for anything unmapped
    always_comb begin
        RD = '0;
        if (is_status) begin
            RD = 32'(status);
        end else if (is_ch) begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_sel == 3'(i)) begin
                    case (reg_sel)
                        REG_CTRL:   RD = {28'd0, ctrl_arr[i]};
                        REG_PRESET: RD = 32'(preset_arr[i]);
                        REG_COUNT:  RD = 32'(count_arr[i]);
                        default:    RD = '0;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_tc_multi.sv
// Bench for tc_multi (NCH=2, CNT_W=8): directed scenarios with fixed
// expectations plus randomized traffic scored against a reference model.
module tb_tc_multi;

    localparam logic [15:0] BASE     = 16'h7F00;
    localparam int          NCH      = 2;
    localparam int          CNT_W    = 8;
    localparam logic [15:0] A_STATUS = BASE + 16'h0080;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] RD;
    logic        IRQ;

    tc_multi #(.BASE(BASE), .NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wd    (wd),
        .RD    (RD),
        .IRQ   (IRQ)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] rd;
        logic        irq;
        logic [15:0] a;
    } exp_t;
    exp_t sb[$];

    // Reference model: per channel phase 0=idle, 1=load pending, 2=counting
    bit       m_en   [NCH];
    bit [1:0] m_mode [NCH];
    bit       m_im   [NCH];
    int       m_pre  [NCH];
    int       m_cnt  [NCH];
    int       m_ph   [NCH];
    bit       m_st   [NCH];

    function automatic logic [15:0] a_reg(input int ch, input int r);
        return BASE + 16'(ch * 16 + r);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_en[c] = 0; m_mode[c] = 0; m_im[c] = 0;
            m_pre[c] = 0; m_cnt[c] = 0; m_ph[c] = 0; m_st[c] = 0;
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [15:0] a);
        logic [15:0] off;
        logic [31:0] s;
        int ch;
        off = a - BASE;
        s = 0;
        for (int c = 0; c < NCH; c++) s[c] = m_st[c];
        if (off >= 16'h0100) return 0;
        if (off[7:0] == 8'h80) return s;
        if (off[7]) return 0;
        ch = int'(off[6:4]);
        if (ch >= NCH) return 0;
        case (off[3:0])
            4'h0: return {28'd0, m_im[ch], m_mode[ch], m_en[ch]};
            4'h4: return 32'(m_pre[ch]);
            4'h8: return 32'(m_cnt[ch]);
            default: return 0;
        endcase
    endfunction

    function automatic logic model_irq();
        logic r;
        r = 0;
        for (int c = 0; c < NCH; c++) r |= m_st[c] & m_im[c];
        return r;
    endfunction

    // Advance the model by one clock edge given that cycle's bus access
    task automatic model_step(input logic w, input logic [15:0] a, input logic [31:0] d);
        logic [15:0] off;
        bit valid, is_stat, chw, term, pulse;
        int wch;
        off     = a - BASE;
        valid   = w && (off < 16'h0100);
        is_stat = valid && (off[7:0] == 8'h80);
        wch     = int'(off[6:4]);
        chw     = valid && !off[7] && (wch < NCH);
        for (int c = 0; c < NCH; c++) begin
            term  = 0;
            pulse = (m_mode[c] == 2'b10);
            if (chw && wch == c && off[3:0] == 4'h0) begin
                m_en[c] = d[0]; m_mode[c] = d[2:1]; m_im[c] = d[3];
                if (m_ph[c] == 0 && d[0]) m_ph[c] = 1;
            end else if (chw && wch == c && off[3:0] == 4'h4) begin
                m_pre[c] = int'(d[CNT_W-1:0]);
            end else begin
                case (m_ph[c])
                    0: if (m_en[c]) m_ph[c] = 1;
                    1: if (!m_en[c]) m_ph[c] = 0;
                       else begin m_cnt[c] = m_pre[c]; m_ph[c] = 2; end
                    default: begin
                        if (!m_en[c]) m_ph[c] = 0;
                        else if (m_cnt[c] <= 1) begin
                            term = 1;
                            if (m_mode[c] == 2'b00) begin m_en[c] = 0; m_ph[c] = 0; end
                            else m_cnt[c] = m_pre[c];
                        end else m_cnt[c] = m_cnt[c] - 1;
                    end
                endcase
            end
            m_st[c] = term || (m_st[c] && !(is_stat && d[c]) && !pulse);
        end
    endtask

    // Called at a falling edge: present the access and queue its expectation
    task automatic drive(input logic w, input logic [15:0] a, input logic [31:0] d);
        exp_t e;
        we = w; addr = a; wd = d;
        e.rd = model_rd(a); e.irq = model_irq(); e.a = a;
        sb.push_back(e);
    endtask

    task automatic finish_cycle(input logic w, input logic [15:0] a, input logic [31:0] d);
        @(posedge clk);
        model_step(w, a, d);
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic tick(input logic w, input logic [15:0] a, input logic [31:0] d);
        drive(w, a, d);
        finish_cycle(w, a, d);
    endtask

    task automatic xfer(input logic w, input logic [15:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_irq, input string nm);
        drive(w, a, d);
        #1;
        chk({nm, "_rd"}, RD, exp_rd);
        chk({nm, "_irq"}, 32'(IRQ), 32'(exp_irq));
        finish_cycle(w, a, d);
    endtask

    task automatic peek(input logic [15:0] a, input logic [31:0] exp_rd, input logic exp_irq,
                        input string nm);
        xfer(1'b0, a, 32'd0, exp_rd, exp_irq, nm);
    endtask

    // Monitor: score every presented access against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("sb_rd_%h", e.a), RD, e.rd);
                chk($sformatf("sb_irq_%h", e.a), 32'(IRQ), 32'(e.irq));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic [15:0] a;
        int r, ch, rg;
        we = 1'b0; addr = 16'h0; wd = 32'h0; reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        peek(a_reg(0, 0), 32'h0, 1'b0, "rst_ctrl0");
        peek(a_reg(1, 4), 32'h0, 1'b0, "rst_preset1");
        peek(a_reg(0, 8), 32'h0, 1'b0, "rst_count0");
        peek(A_STATUS,    32'h0, 1'b0, "rst_status");

        // 1: one-shot, preset 3, flag on 4th edge after the enabling write
        tick(1'b1, a_reg(0, 4), 32'd3);
        tick(1'b1, a_reg(0, 0), 32'h9);
        peek(a_reg(0, 8), 32'd0, 1'b0, "t1_cnt_e0");
        peek(a_reg(0, 8), 32'd3, 1'b0, "t1_cnt_e1");
        peek(a_reg(0, 8), 32'd2, 1'b0, "t1_cnt_e2");
        peek(a_reg(0, 8), 32'd1, 1'b0, "t1_cnt_e3");
        peek(A_STATUS,    32'd1, 1'b1, "t1_flag_e4");
        peek(a_reg(0, 0), 32'h8, 1'b1, "t1_en_cleared");
        tick(1'b1, A_STATUS, 32'h1);
        peek(A_STATUS,    32'd0, 1'b0, "t1_w1c");

        // 2: periodic ch1, preset 2
        tick(1'b1, a_reg(1, 4), 32'd2);
        tick(1'b1, a_reg(1, 0), 32'hB);
        tick(1'b0, A_STATUS, 32'd0);
        peek(a_reg(1, 8), 32'd2, 1'b0, "t2_cnt_a");
        peek(a_reg(1, 8), 32'd1, 1'b0, "t2_cnt_b");
        xfer(1'b1, A_STATUS, 32'h2, 32'h2, 1'b1, "t2_flag_then_w1c");
        peek(A_STATUS,    32'd0, 1'b0, "t2_cleared");
        peek(A_STATUS,    32'd2, 1'b1, "t2_reset_flag");
        peek(a_reg(1, 8), 32'd1, 1'b1, "t2_cnt_c");
        tick(1'b1, a_reg(1, 0), 32'h0);
        tick(1'b1, A_STATUS, 32'h2);
        peek(A_STATUS,    32'd0, 1'b0, "t2_off");

        // 3: pulse mode ch0, preset 4 -> one-cycle flag every 4 cycles
        tick(1'b1, a_reg(0, 4), 32'd4);
        tick(1'b1, a_reg(0, 0), 32'hD);
        for (int k = 0; k <= 12; k++) begin
            logic p;
            p = (k >= 5) && ((k - 5) % 4 == 0);
            peek(A_STATUS, 32'(p), p, $sformatf("t3_pulse_%0d", k));
        end
        tick(1'b1, a_reg(0, 0), 32'h0);
        tick(1'b0, A_STATUS, 32'h0);

        // 4: clear colliding with terminal, IM=0
        tick(1'b1, a_reg(0, 4), 32'd2);
        tick(1'b1, a_reg(0, 0), 32'h1);
        tick(1'b0, A_STATUS, 32'h0);
        tick(1'b0, A_STATUS, 32'h0);
        xfer(1'b1, A_STATUS, 32'h1, 32'h0, 1'b0, "t4_w1c_at_term");
        peek(A_STATUS,    32'd1, 1'b0, "t4_set_wins");
        peek(a_reg(0, 0), 32'd0, 1'b0, "t4_en_cleared");
        tick(1'b1, A_STATUS, 32'h1);

        // 5: CNT_W truncation, async reset mid-count, out-of-range channel
        tick(1'b1, a_reg(1, 4), 32'd3);
        tick(1'b1, a_reg(1, 0), 32'hB);
        tick(1'b1, a_reg(0, 4), 32'hABCD_01FF);
        peek(a_reg(0, 4), 32'h0000_00FF, 1'b0, "t5_preset_trunc");
        tick(1'b1, a_reg(0, 0), 32'h1);
        repeat (128) tick(1'b0, A_STATUS, 32'h0);
        peek(a_reg(0, 8), 32'h80, 1'b1, "t5_cnt_mid");
        #3 reset = 1'b1;
        #1;
        chk("t5_async_irq", 32'(IRQ), 32'd0);
        chk("t5_async_count", RD, 32'd0);
        addr = A_STATUS;
        #1;
        chk("t5_async_status", RD, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        peek(a_reg(0, 4), 32'd0, 1'b0, "t5_preset_zero");
        tick(1'b1, BASE + 16'h0020, 32'hF);
        tick(1'b1, BASE + 16'h0024, 32'd5);
        peek(BASE + 16'h0020, 32'd0, 1'b0, "t5_ch2_ignored");
        repeat (4) tick(1'b0, A_STATUS, 32'h0);
        peek(A_STATUS, 32'd0, 1'b0, "t5_status_quiet");

        // Randomized traffic against the reference model
        for (int i = 0; i < 800; i++) begin
            r  = $urandom_range(0, 99);
            ch = $urandom_range(0, 2);
            rg = 4 * $urandom_range(0, 3);
            if (r < 15) begin
                d = {$urandom, 4'h0} & 32'hFFFF_FFF0;
                d[3:1] = 3'($urandom_range(0, 7));
                d[0]   = ($urandom_range(0, 3) != 0);
                tick(1'b1, a_reg(ch, 0), d);
            end else if (r < 30) begin
                d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 5));
                tick(1'b1, a_reg(ch, ($urandom_range(0, 4) == 0) ? 8 : 4), d);
            end else if (r < 38) begin
                tick(1'b1, A_STATUS, $urandom);
            end else begin
                case ($urandom_range(0, 4))
                    0:       a = A_STATUS;
                    1:       a = BASE + 16'h0084;
                    2:       a = BASE - 16'h0004;
                    3:       a = BASE + 16'h0100;
                    default: a = a_reg(ch, rg);
                endcase
                tick(1'b0, a, 32'h0);
            end
        end

        repeat (2) @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
